audio_scope_capture: RTL and testbench

- Audio-side producer for the VGA waveform display. It deserialises the left channel of the codec ADC I2S stream and decimates it.
- An oscilloscope-style trigger gates which samples reach the display: free-run or rising-level trigger.
- Emits a one-cycle o_sample_valid with held o_audio_data, which the display's 2-flop synchroniser consumes.
- Runs on the audio bit clock (BCLK), which is slower than 25 MHz, so a one-cycle pulse is always captured downstream.

---
 rtl/audio_pkg.sv | 18 +
 rtl/i2s_rx_word.sv | 86 ++++++++
 rtl/audio_scope_capture.sv | 156 +++++++++++++++
 tb/tb_audio_scope_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and widths for the audio scope capture path.
package audio_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    TRIG_FREE,
    TRIG_ARMED,
    TRIG_CAPTURE,
    TRIG_HOLDOFF
  } trig_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_word.sv
// I2S left-channel word receiver: LRCK edge detect, MSB-first shift register,
// completion strobe and aborted-word error pulse.
module i2s_rx_word
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = audio_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrck,
  input  logic              i_dat,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_stb,
  output logic              o_word_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic              lrck_q, lrck_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              word_stb_q, word_stb_d;
  logic              word_err_q, word_err_d;
  logic              lrck_fall_c, lrck_rise_c;

  assign lrck_fall_c = lrck_q & ~i_lrck;
  assign lrck_rise_c = ~lrck_q & i_lrck;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RX_IDLE;
      lrck_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      word_stb_q <= 1'b0;
      word_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrck_q     <= lrck_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      word_stb_q <= word_stb_d;
      word_err_q <= word_err_d;
    end
  end

  // The falling-edge cycle carries the I2S delay bit, so shifting starts on the next one.
  always_comb begin
    state_d    = state_q;
    lrck_d     = i_lrck;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    word_stb_d = 1'b0;
    word_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (lrck_fall_c) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = '0;
        end
      end
      RX_SHIFT: begin
        if (lrck_fall_c || lrck_rise_c) begin
          word_err_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = lrck_fall_c ? RX_SHIFT : RX_IDLE;
        end else begin
          shreg_d   = {shreg_q[DATA_W-2:0], i_dat};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            word_stb_d = 1'b1;
            state_d    = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_word     = shreg_q;
  assign o_word_stb = word_stb_q;
  assign o_word_err = word_err_q;

endmodule

// File: rtl/audio_scope_capture.sv
// Audio-side scope producer: I2S left-channel capture, pick decimation and
// free-run / rising-level trigger gating of samples sent to the display.
module audio_scope_capture
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W     = audio_pkg::DATA_W,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FRAME_LEN  = 560,
  parameter int signed   TRIG_LEVEL = 0,
  parameter int unsigned HOLDOFF    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_adclrck,
  input  logic                     i_adcdat,
  input  logic                     i_trig_en,
  output logic                     o_sample_valid,
  output logic signed [DATA_W-1:0] o_audio_data,
  output logic                     o_frame_start,
  output logic                     o_armed,
  output logic                     o_word_err
);

  localparam int unsigned DEC_W = 8;
  localparam int unsigned FC_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned HO_W  = $clog2(HOLDOFF + 2);
  localparam logic signed [DATA_W-1:0] TRIG_LVL = DATA_W'(TRIG_LEVEL);

  logic [DATA_W-1:0]        rx_word;
  logic                     rx_word_stb;
  logic                     rx_word_err;
  logic signed [DATA_W-1:0] cur_c;

  trig_state_t              state_q, state_d;
  logic [DEC_W-1:0]         dec_cnt_q, dec_cnt_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic [FC_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic [HO_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic                     sample_valid_q, sample_valid_d;
  logic signed [DATA_W-1:0] audio_data_q, audio_data_d;
  logic                     frame_start_q, frame_start_d;
  logic                     armed_q, armed_d;

  logic                     dec_stb_c;
  logic                     emit_c;
  logic [FC_W-1:0]          frame_nxt_c;
  logic [HO_W-1:0]          hold_nxt_c;
  trig_state_t              rearm_c, post_frame_c;

  i2s_rx_word #(
    .DATA_W (DATA_W)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_lrck     (i_adclrck),
    .i_dat      (i_adcdat),
    .o_word     (rx_word),
    .o_word_stb (rx_word_stb),
    .o_word_err (rx_word_err)
  );

  assign cur_c = $signed(rx_word);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= TRIG_FREE;
      dec_cnt_q      <= '0;
      prev_q         <= '0;
      frame_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      sample_valid_q <= 1'b0;
      audio_data_q   <= '0;
      frame_start_q  <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      dec_cnt_q      <= dec_cnt_d;
      prev_q         <= prev_d;
      frame_cnt_q    <= frame_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      sample_valid_q <= sample_valid_d;
      audio_data_q   <= audio_data_d;
      frame_start_q  <= frame_start_d;
      armed_q        <= armed_d;
    end
  end

  // Pick the first word of every DECIM-word group.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_stb_c = 1'b0;
    if (rx_word_stb) begin
      dec_stb_c = (dec_cnt_q == '0);
      dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + DEC_W'(1);
    end
  end

  // Trigger FSM; everything advances only on a decimated word.
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    frame_cnt_d    = frame_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    sample_valid_d = 1'b0;
    frame_start_d  = 1'b0;
    audio_data_d   = audio_data_q;
    emit_c         = 1'b0;
    frame_nxt_c    = frame_cnt_q + FC_W'(1);
    hold_nxt_c     = hold_cnt_q + HO_W'(1);
    rearm_c        = i_trig_en ? TRIG_ARMED : TRIG_FREE;
    post_frame_c   = (HOLDOFF == 0) ? rearm_c : TRIG_HOLDOFF;
    if (dec_stb_c) begin
      prev_d = cur_c;
      unique case (state_q)
        TRIG_FREE: begin
          emit_c = 1'b1;
          if (i_trig_en) state_d = TRIG_ARMED;
        end
        TRIG_ARMED: begin
          if (!i_trig_en) begin
            state_d = TRIG_FREE;
          end else if (prev_q < TRIG_LVL && cur_c >= TRIG_LVL) begin
            emit_c        = 1'b1;
            frame_start_d = 1'b1;
            frame_cnt_d   = FC_W'(1);
            hold_cnt_d    = '0;
            state_d       = (FRAME_LEN <= 1) ? post_frame_c : TRIG_CAPTURE;
          end
        end
        TRIG_CAPTURE: begin
          emit_c      = 1'b1;
          frame_cnt_d = frame_nxt_c;
          hold_cnt_d  = '0;
          if (frame_nxt_c == FC_W'(FRAME_LEN)) state_d = post_frame_c;
        end
        TRIG_HOLDOFF: begin
          hold_cnt_d = hold_nxt_c;
          if (hold_nxt_c == HO_W'(HOLDOFF)) state_d = rearm_c;
        end
        default: state_d = TRIG_FREE;
      endcase
    end
    if (emit_c) begin
      sample_valid_d = 1'b1;
      audio_data_d   = cur_c;
    end
    armed_d = (state_d == TRIG_ARMED);
  end

  assign o_sample_valid = sample_valid_q;
  assign o_audio_data   = audio_data_q;
  assign o_frame_start  = frame_start_q;
  assign o_armed        = armed_q;
  assign o_word_err     = rx_word_err;

endmodule

// File: tb/tb_audio_scope_capture.sv
// Directed scoreboard bench for audio_scope_capture (DECIM=1 and DECIM=4 instances).
module tb_audio_scope_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst4, lrck, dat, trig_en;
  logic trig4 = 1'b0;

  logic               valid1, fs1, armed1, err1;
  logic signed [15:0] data1;
  logic               valid4, fs4, armed4, err4;
  logic signed [15:0] data4;

  audio_scope_capture #(.DECIM(1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_adclrck      (lrck),
    .i_adcdat       (dat),
    .i_trig_en      (trig_en),
    .o_sample_valid (valid1),
    .o_audio_data   (data1),
    .o_frame_start  (fs1),
    .o_armed        (armed1),
    .o_word_err     (err1)
  );

  audio_scope_capture #(.DECIM(4)) dut4 (
    .i_clk          (clk),
    .i_rst          (rst4),
    .i_adclrck      (lrck),
    .i_adcdat       (dat),
    .i_trig_en      (trig4),
    .o_sample_valid (valid4),
    .o_audio_data   (data4),
    .o_frame_start  (fs4),
    .o_armed        (armed4),
    .o_word_err     (err4)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, n_str = 0, n_fs = 0, n_err = 0, last_str_cyc = 0, lsb_cyc = 0;
  logic [15:0] fs_val = '0;
  logic [16:0] exp_q[$];
  logic [16:0] exp4_q[$];
  logic [16:0] e1, e4;

  // Reference behaviour of the trigger path: mode 0 free, 1 armed, 2 capture, 3 holdoff.
  int m_mode = 0, m_cnt = 0, m_hold = 0, m_frames = 0, sine_k = 0;
  logic signed [15:0] m_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic signed [15:0] w);
    logic emit, fs;
    emit = 1'b0;
    fs   = 1'b0;
    case (m_mode)
      0: begin
        emit = 1'b1;
        if (trig_en) m_mode = 1;
      end
      1: begin
        if (!trig_en) m_mode = 0;
        else if (m_prev < 0 && w >= 0) begin
          emit = 1'b1; fs = 1'b1; m_cnt = 1; m_mode = 2;
        end
      end
      2: begin
        emit = 1'b1;
        m_cnt++;
        if (m_cnt == 560) begin m_mode = 3; m_hold = 0; m_frames++; end
      end
      default: begin
        m_hold++;
        if (m_hold == 64) m_mode = trig_en ? 1 : 0;
      end
    endcase
    m_prev = w;
    if (emit) exp_q.push_back({fs, w});
  endtask

  // One LRCK period: 20-cycle left half (delay bit, nbits data, padding) then 20-cycle right half.
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r, input int nbits, input int rst_at);
    logic [15:0] ls, rs;
    int left_len;
    ls = l;
    rs = r;
    left_len = (nbits < 16) ? nbits + 1 : 20;
    for (int i = 0; i < left_len; i++) begin
      @(negedge clk);
      lrck = 1'b0;
      if (i >= 1 && i <= nbits) begin dat = ls[15]; ls = {ls[14:0], 1'b0}; end
      else dat = 1'b1;
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        check("rst_valid", 32'(valid1), 0);
        check("rst_data", 32'($unsigned(data1)), 0);
        check("rst_fstart", 32'(fs1), 0);
        check("rst_armed", 32'(armed1), 0);
        check("rst_err", 32'(err1), 0);
        m_mode = 0; m_prev = '0; m_cnt = 0; m_hold = 0;
      end
      if (i == 16 && rst_at < 0) begin
        lsb_cyc = cyc;
        model_word(l);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lrck = 1'b1;
      if (i >= 1 && i <= 16) begin dat = rs[15]; rs = {rs[14:0], 1'b0}; end
      else dat = 1'b0;
      if (i == 10) check("armed", 32'(armed1), 32'(m_mode == 1));
    end
  endtask

  function automatic logic [15:0] sine_word(input int k);
    real v;
    v = 1000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 40.0);
    return 16'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (err1 === 1'b1) n_err++;
    if (valid1 === 1'b1) begin
      n_str++;
      last_str_cyc = cyc;
      if (fs1 === 1'b1) begin n_fs++; fs_val = data1; end
      check("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e1 = exp_q.pop_front();
        check("sample_data", 32'($unsigned(data1)), 32'(e1[15:0]));
        check("frame_start", 32'(fs1), 32'(e1[16]));
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (valid4 === 1'b1) begin
      check("dec4_strobe_expected", 32'(exp4_q.size() != 0), 1);
      if (exp4_q.size() != 0) begin
        e4 = exp4_q.pop_front();
        check("dec4_data", 32'($unsigned(data4)), 32'(e4[15:0]));
        check("dec4_fstart", 32'(fs4), 32'(e4[16]));
      end
    end
  end

  initial begin
    int s0, s1, f0, e0;
    rst = 1'b1; rst4 = 1'b1; lrck = 1'b1; dat = 1'b0; trig_en = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_valid", 32'(valid1), 0);
    check("reset_data", 32'($unsigned(data1)), 0);
    check("reset_fstart", 32'(fs1), 0);
    check("reset_armed", 32'(armed1), 0);
    check("reset_err", 32'(err1), 0);
    check("reset_dec4_valid", 32'(valid4), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Free-run, every word: left words out, right words never.
    s0 = n_str;
    send_pair(16'h1234, 16'h7FFF, 16, -1);
    check("latency_1", 32'(last_str_cyc - lsb_cyc), 2);
    send_pair(16'h8001, 16'h7FFF, 16, -1);
    check("latency_2", 32'(last_str_cyc - lsb_cyc), 2);
    check("freerun_strobes", 32'(n_str - s0), 2);

    // Decimate-by-4 ramp on the second instance.
    @(negedge clk);
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    exp4_q.push_back({1'b0, 16'd0});
    exp4_q.push_back({1'b0, 16'd4});
    exp4_q.push_back({1'b0, 16'd8});
    for (int k = 0; k < 12; k++) send_pair(16'(k), 16'h7FFF, 16, -1);
    repeat (4) @(negedge clk);
    check("dec4_all_emitted", 32'(exp4_q.size()), 0);
    check("dec4_armed", 32'(armed4), 0);
    check("dec4_err", 32'(err4), 0);
    rst4 = 1'b1;

    // Trigger never met: armed, silent; dropping enable returns to free-run.
    trig_en = 1'b1;
    s0 = n_str;
    send_pair(16'(-500), 16'h7FFF, 16, -1);
    check("arming_sample", 32'(n_str - s0), 1);
    s1 = n_str;
    for (int k = 0; k < 9; k++) send_pair(16'(-500), 16'h7FFF, 16, -1);
    check("armed_silent", 32'(n_str - s1), 0);
    check("armed_held", 32'(armed1), 1);
    trig_en = 1'b0;
    s0 = n_str;
    for (int k = 0; k < 3; k++) send_pair(16'(-500), 16'h7FFF, 16, -1);
    check("disarm_strobes", 32'(n_str - s0), 2);
    check("disarm_armed", 32'(armed1), 0);

    // Truncated word then a clean one.
    e0 = n_err;
    s0 = n_str;
    send_pair(16'hABCD, 16'h7FFF, 9, -1);
    check("trunc_no_strobe", 32'(n_str - s0), 0);
    send_pair(16'h00FF, 16'h7FFF, 16, -1);
    check("word_err_pulses", 32'(n_err - e0), 1);
    check("after_err_strobe", 32'(n_str - s0), 1);

    // Triggered sine: one full frame, holdoff, then re-armed.
    trig_en = 1'b1;
    s0 = n_str;
    f0 = n_fs;
    for (int p = 0; p < 1200 && !(m_frames == 1 && m_mode == 1); p++) begin
      send_pair(sine_word(sine_k), 16'h7FFF, 16, -1);
      sine_k++;
    end
    check("frame_starts", 32'(n_fs - f0), 1);
    check("frame_strobes", 32'(n_str - s0), 561);
    check("trig_value_nonneg", 32'(fs_val[15]), 0);
    check("rearmed", 32'(armed1), 1);

    // Second capture, reset mid-word at sample 300.
    for (int p = 0; p < 600 && !(m_mode == 2 && m_cnt == 300); p++) begin
      send_pair(sine_word(sine_k), 16'h7FFF, 16, -1);
      sine_k++;
    end
    check("capturing_before_reset", 32'(armed1), 0);
    check("data_before_reset_nonzero", 32'(data1 != 16'sd0), 1);
    send_pair(sine_word(sine_k), 16'h7FFF, 16, 6);
    sine_k++;
    s0 = n_str;
    f0 = n_fs;
    for (int k = 0; k < 2; k++) begin
      send_pair(sine_word(sine_k), 16'h7FFF, 16, -1);
      sine_k++;
    end
    check("post_reset_strobes", 32'(n_str - s0), 1);
    check("post_reset_no_fstart", 32'(n_fs - f0), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("dec4_scoreboard_drained", 32'(exp4_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
